// File: rtl/diff_scan_unit.sv
// Multi-cycle first-differing-bit scanner: XORs two operands and walks the
// difference vector CHUNK bits per cycle from the LSB or MSB end.
module diff_scan_unit #(
   parameter int WIDTH = 32,
   parameter int CHUNK = 8,
   parameter int IDX_W = $clog2(WIDTH)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] op_a,
   input  logic [WIDTH-1:0] op_b,
   input  logic             dir,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [IDX_W-1:0] index,
   output logic             equal
);

   localparam int NCH   = WIDTH / CHUNK;
   localparam int PW    = (NCH > 1) ? $clog2(NCH) : 1;
   localparam int OFF_W = (CHUNK > 1) ? $clog2(CHUNK) : 1;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SCAN = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t              state_r;
   logic [WIDTH-1:0]    x_r;
   logic                dir_r;
   logic [PW-1:0]       p_r;
   logic [IDX_W-1:0]    index_r;
   logic                equal_r;
   logic                in_ready_r;
   logic                out_valid_r;

   logic [PW-1:0]       chunk_idx_s;
   logic [IDX_W-1:0]    base_s;
   logic [CHUNK-1:0]    chunk_s;
   logic [OFF_W-1:0]    off_s;
   logic [IDX_W-1:0]    idx_s;

   function automatic logic [OFF_W-1:0] lowest_set(input logic [CHUNK-1:0] v);
      logic [OFF_W-1:0] pos;
      pos = '0;
      for (int i = CHUNK - 1; i >= 0; i--) begin
         if (v[i]) begin
            pos = OFF_W'(i);
         end
      end
      return pos;
   endfunction

   function automatic logic [OFF_W-1:0] highest_set(input logic [CHUNK-1:0] v);
      logic [OFF_W-1:0] pos;
      pos = '0;
      for (int i = 0; i < CHUNK; i++) begin
         if (v[i]) begin
            pos = OFF_W'(i);
         end
      end
      return pos;
   endfunction

   // Select the chunk under inspection and locate its candidate bit
   always_comb begin
      chunk_idx_s = '0;
      base_s      = '0;
      chunk_s     = '0;
      off_s       = '0;
      idx_s       = '0;
      // MSB-first walks the chunks from the top down
      chunk_idx_s = dir_r ? (PW'(NCH - 1) - p_r) : p_r;
      base_s      = IDX_W'(chunk_idx_s) * IDX_W'(CHUNK);
      chunk_s     = CHUNK'(x_r >> base_s);
      off_s       = dir_r ? highest_set(chunk_s) : lowest_set(chunk_s);
      idx_s       = base_s + IDX_W'(off_s);
   end

   // Control FSM with registered handshake and result outputs
   always_ff @(posedge clk) begin
      if (rst) begin
         state_r     <= IDLE;
         x_r         <= '0;
         dir_r       <= 1'b0;
         p_r         <= '0;
         index_r     <= '0;
         equal_r     <= 1'b0;
         in_ready_r  <= 1'b1;
         out_valid_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  x_r        <= op_a ^ op_b;
                  dir_r      <= dir;
                  p_r        <= '0;
                  in_ready_r <= 1'b0;
                  state_r    <= SCAN;
               end
            end
            SCAN: begin
               if (chunk_s != '0) begin
                  index_r     <= idx_s;
                  equal_r     <= 1'b0;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else if (p_r == PW'(NCH - 1)) begin
                  index_r     <= '0;
                  equal_r     <= 1'b1;
                  out_valid_r <= 1'b1;
                  state_r     <= DONE;
               end else begin
                  p_r <= p_r + PW'(1);
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid_r <= 1'b0;
                  in_ready_r  <= 1'b1;
                  state_r     <= IDLE;
               end
            end
            default: begin
               state_r     <= IDLE;
               in_ready_r  <= 1'b1;
               out_valid_r <= 1'b0;
            end
         endcase
      end
   end

   assign in_ready  = in_ready_r;
   assign out_valid = out_valid_r;
   assign index     = index_r;
   assign equal     = equal_r;

endmodule

// File: tb/tb_diff_scan_unit.sv
// Scoreboard bench for diff_scan_unit: directed vectors on the default
// configuration plus a sweep over (16,16), (32,4) and (64,8).
module tb_diff_scan_unit;

   typedef struct {
      int          d;
      logic [63:0] idx;
      logic        eq;
      int          lat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst;
   logic [3:0]  iv, irdy, ov, eqo, dr, ordy;
   logic [63:0] opa [4];
   logic [63:0] opb [4];
   logic [4:0]  ix0;
   logic [3:0]  ix1;
   logic [4:0]  ix2;
   logic [5:0]  ix3;
   logic [63:0] ixw [4];

   int          tests = 0;
   int          fails = 0;
   int          cyc = 0;
   exp_t        q[$];
   bit          seen [4];
   logic [63:0] hix [4];
   logic        heq [4];
   int          wd [4] = '{32, 16, 32, 64};
   int          ch [4] = '{8, 16, 4, 8};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   diff_scan_unit #(.WIDTH(32), .CHUNK(8)) u0 (
      .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
      .op_a(opa[0][31:0]), .op_b(opb[0][31:0]), .dir(dr[0]),
      .out_valid(ov[0]), .out_ready(ordy[0]), .index(ix0), .equal(eqo[0]));
   diff_scan_unit #(.WIDTH(16), .CHUNK(16)) u1 (
      .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
      .op_a(opa[1][15:0]), .op_b(opb[1][15:0]), .dir(dr[1]),
      .out_valid(ov[1]), .out_ready(ordy[1]), .index(ix1), .equal(eqo[1]));
   diff_scan_unit #(.WIDTH(32), .CHUNK(4)) u2 (
      .clk(clk), .rst(rst), .in_valid(iv[2]), .in_ready(irdy[2]),
      .op_a(opa[2][31:0]), .op_b(opb[2][31:0]), .dir(dr[2]),
      .out_valid(ov[2]), .out_ready(ordy[2]), .index(ix2), .equal(eqo[2]));
   diff_scan_unit #(.WIDTH(64), .CHUNK(8)) u3 (
      .clk(clk), .rst(rst), .in_valid(iv[3]), .in_ready(irdy[3]),
      .op_a(opa[3]), .op_b(opb[3]), .dir(dr[3]),
      .out_valid(ov[3]), .out_ready(ordy[3]), .index(ix3), .equal(eqo[3]));

   assign ixw[0] = {59'd0, ix0};
   assign ixw[1] = {60'd0, ix1};
   assign ixw[2] = {59'd0, ix2};
   assign ixw[3] = {58'd0, ix3};

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] req);
      tests++;
      if (act !== req) begin
         fails++;
         $display("FAIL %s: actual=0x%0h required=0x%0h (t=%0t)", nm, act, req, $time);
      end
   endtask

   function automatic exp_t mk(input int d, input logic [63:0] idx, input logic eq, input int lat);
      exp_t e;
      e.d = d; e.idx = idx; e.eq = eq; e.lat = lat; e.acc = 0;
      return e;
   endfunction

   // Behavioural reference: first differing bit overall, latency from its chunk's scan position
   function automatic exp_t model(input int d, input logic [63:0] a, input logic [63:0] b, input logic di);
      logic [63:0] x;
      int          pos, nch;
      x   = a ^ b;
      pos = -1;
      nch = wd[d] / ch[d];
      if (!di) begin
         for (int i = wd[d] - 1; i >= 0; i--) if (x[i]) pos = i;
      end else begin
         for (int i = 0; i < wd[d]; i++) if (x[i]) pos = i;
      end
      if (pos < 0) return mk(d, 64'd0, 1'b0 | 1'b1, nch);
      return mk(d, 64'(pos), 1'b0, di ? (nch - pos / ch[d]) : (pos / ch[d] + 1));
   endfunction

   task automatic mon(input int d);
      exp_t e;
      if (ov[d]) begin
         if (!seen[d]) begin
            chk("pending_expect", 64'(q.size() > 0), 64'd1);
            if (q.size() > 0) begin
               e = q[0];
               chk("dut_id", 64'(d), 64'(e.d));
               chk("index", ixw[d], e.idx);
               chk("equal", {63'd0, eqo[d]}, {63'd0, e.eq});
               chk("latency", 64'(cyc - e.acc), 64'(e.lat));
            end
            hix[d]  = ixw[d];
            heq[d]  = eqo[d];
            seen[d] = 1'b1;
         end else begin
            chk("index_hold", ixw[d], hix[d]);
            chk("equal_hold", {63'd0, eqo[d]}, {63'd0, heq[d]});
         end
         if (ordy[d]) begin
            seen[d] = 1'b0;
            if (q.size() > 0) void'(q.pop_front());
         end
      end
   endtask

   initial begin
      forever begin
         @(negedge clk);
         for (int d = 0; d < 4; d++) begin
            if (rst) seen[d] = 1'b0;
            else mon(d);
         end
      end
   end

   task automatic issue(input int d, input logic [63:0] a, input logic [63:0] b,
                        input logic di, input bit push, input exp_t e);
      exp_t en;
      int   n;
      opa[d] = a; opb[d] = b; dr[d] = di; iv[d] = 1'b1;
      n = 0;
      while (!irdy[d] && n < 50) begin
         @(negedge clk);
         n++;
      end
      chk("accept_ready", {63'd0, irdy[d]}, 64'd1);
      en = e;
      en.acc = cyc + 1;
      if (push && irdy[d]) q.push_back(en);
      @(posedge clk);
      #1 iv[d] = 1'b0;
   endtask

   task automatic wait_idle(input int d);
      int n;
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!irdy[d] && n < 100);
      chk("return_idle", {63'd0, irdy[d]}, 64'd1);
   endtask

   initial begin
      exp_t e;
      logic [63:0] a, b;
      logic di;
      int n;
      bit any_ov;
      rst = 1'b1; iv = '0; dr = '0; ordy = '1;
      for (int i = 0; i < 4; i++) begin
         opa[i] = '0; opb[i] = '0;
      end
      repeat (3) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      chk("rst_out_valid", {63'd0, ov[0]}, 64'd0);
      chk("rst_in_ready", {63'd0, irdy[0]}, 64'd1);
      chk("rst_index", ixw[0], 64'd0);
      chk("rst_equal", {63'd0, eqo[0]}, 64'd0);

      issue(0, 64'h0000_0100, 64'd0, 1'b0, 1'b1, mk(0, 64'd8, 1'b0, 2));           wait_idle(0);
      issue(0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b0, 1'b1, mk(0, 64'd0, 1'b1, 4));   wait_idle(0);
      issue(0, 64'hDEAD_BEEF, 64'hDEAD_BEEF, 1'b1, 1'b1, mk(0, 64'd0, 1'b1, 4));   wait_idle(0);
      issue(0, 64'h8000_0001, 64'd0, 1'b1, 1'b1, mk(0, 64'd31, 1'b0, 1));          wait_idle(0);
      issue(0, 64'h8000_0001, 64'd0, 1'b0, 1'b1, mk(0, 64'd0, 1'b0, 1));           wait_idle(0);
      issue(0, 64'h0000_00F0, 64'h0000_0010, 1'b1, 1'b1, mk(0, 64'd7, 1'b0, 4));   wait_idle(0);

      // Backpressure: result must hold while new requests are offered
      ordy[0] = 1'b0;
      issue(0, 64'h0001_0000, 64'd0, 1'b0, 1'b1, mk(0, 64'd16, 1'b0, 3));
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!ov[0] && n < 20);
      chk("bp_valid_rise", {63'd0, ov[0]}, 64'd1);
      for (int i = 0; i < 5; i++) begin
         iv[0] = 1'b1; opa[0] = {32'd0, $urandom}; opb[0] = 64'd0; dr[0] = ~dr[0];
         chk("bp_in_ready", {63'd0, irdy[0]}, 64'd0);
         chk("bp_out_valid", {63'd0, ov[0]}, 64'd1);
         @(negedge clk);
      end
      @(posedge clk);
      #1 iv[0] = 1'b0; ordy[0] = 1'b1;
      @(negedge clk);
      @(negedge clk);
      chk("bp_release_valid", {63'd0, ov[0]}, 64'd0);
      chk("bp_release_ready", {63'd0, irdy[0]}, 64'd1);
      issue(0, 64'h0000_0002, 64'd0, 1'b1, 1'b1, mk(0, 64'd1, 1'b0, 4));           wait_idle(0);

      // Reset during the second SCAN cycle aborts the operation
      issue(0, 64'h0100_0000, 64'd0, 1'b0, 1'b0, mk(0, 64'd0, 1'b0, 0));
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      @(negedge clk);
      chk("abort_in_ready", {63'd0, irdy[0]}, 64'd1);
      chk("abort_index", ixw[0], 64'd0);
      chk("abort_equal", {63'd0, eqo[0]}, 64'd0);
      any_ov = 1'b0;
      for (int i = 0; i < 6; i++) begin
         any_ov = any_ov | ov[0];
         @(negedge clk);
      end
      chk("abort_no_result", {63'd0, any_ov}, 64'd0);
      issue(0, 64'h0100_0000, 64'd0, 1'b0, 1'b1, mk(0, 64'd24, 1'b0, 4));          wait_idle(0);

      // Parameter sweep against the behavioural reference
      for (int d = 1; d < 4; d++) begin
         for (int k = 0; k < 12; k++) begin
            a  = {$urandom, $urandom};
            di = 1'($urandom_range(1, 0));
            case (k % 3)
               0:       b = a;
               1:       b = a ^ (64'd1 << $urandom_range(wd[d] - 1, 0));
               default: b = {$urandom, $urandom};
            endcase
            e = model(d, a, b, di);
            issue(d, a, b, di, 1'b1, e);
            wait_idle(d);
         end
      end

      repeat (3) @(negedge clk);
      chk("queue_drained", 64'(q.size()), 64'd0);
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
